// File: rtl/audio_pkg.sv
// Shared constants and helpers for the multi-channel audio DAC front end.
//   MIDSCALE         offset-binary code for silence
//   clog2            ceiling log2, usable in constant expressions
//   beats_per_frame  32-bit stream beats needed to carry one NCH-channel frame
package audio_pkg;

    localparam logic [15:0] MIDSCALE = 16'h8000;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Two 16-bit samples per beat; an odd channel count leaves the last upper half unused.
    function automatic int unsigned beats_per_frame(input int unsigned nch);
        return (nch + 1) / 2;
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Frame FIFO for the audio DAC front end.
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   push_i/wdata_i write one frame; honoured when not full, or when full and popping
//   pop_i/rdata_o  rdata_o shows the head combinationally; pop_i advances it when not empty
//   full_o/empty_o status from the pointer registers
//   level_o        frames currently stored
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [LW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + LW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

endmodule

// File: rtl/sigma_dac.sv
// First-order sigma-delta modulator.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   din_i   unsigned (offset-binary) level, NBITS wide
//   dout_o  1-bit density output; ones density ~= din_i / 2**NBITS
module sigma_dac #(
    parameter int unsigned NBITS = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NBITS-1:0] din_i,
    output logic             dout_o
);

    logic [NBITS-1:0] acc_q;
    logic [NBITS:0]   sum;
    logic             dout_q;

    // The carry out of the accumulator is the output bit.
    assign sum    = {1'b0, acc_q} + {1'b0, din_i};
    assign dout_o = dout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            acc_q  <= sum[NBITS-1:0];
            dout_q <= sum[NBITS];
        end
    end

endmodule

// File: rtl/audio_dac_mc.sv
// Multi-channel sigma-delta audio DAC front end.
// Packs interleaved 16-bit PCM from a 32-bit stream into NCH-channel frames, queues them,
// and releases one frame per audio_clk_i rising edge into per-channel modulators.
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   audio_clk_i          sample-rate clock (synchronous to clk_i); each rising edge is a tick
//   inport_*             AXI-stream sink; tstrb ignored, tdest filtered against DEST_ID
//   audio_o              1-bit modulator outputs, bit c = channel c
//   level_o              frames queued
//   underrun_o           1-cycle pulse when a tick finds the FIFO empty
//   frame_err_o          1-cycle pulse when tlast does not line up with the frame end
module audio_dac_mc
    import audio_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned NBITS      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DEST_ID    = 0,
    parameter int unsigned UNDER_MUTE = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               audio_clk_i,
    input  logic                               inport_tvalid_i,
    input  logic [31:0]                        inport_tdata_i,
    input  logic [3:0]                         inport_tstrb_i,
    input  logic [3:0]                         inport_tdest_i,
    input  logic                               inport_tlast_i,
    output logic                               inport_tready_o,
    output logic [NCH-1:0]                     audio_o,
    output logic [clog2(FIFO_DEPTH+1)-1:0]     level_o,
    output logic                               underrun_o,
    output logic                               frame_err_o
);

    localparam int unsigned BEATS = beats_per_frame(NCH);
    localparam int unsigned BW    = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int unsigned LW    = clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW    = NCH * 16;

    logic [BW-1:0]         beat_q, beat_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  commit_q, commit_d;
    logic                  frame_err_q, frame_err_d;
    logic                  beat_fire, dest_ok, last_beat;
    logic                  audio_clk_q, tick, pop;
    logic [FW-1:0]         head, pop_data_q;
    logic                  load_q, mute_q, underrun_q;
    logic                  fifo_full, fifo_empty;
    logic [LW-1:0]         level;
    logic [NCH-1:0][15:0]  ch_q;
    logic                  unused_strb;

    assign unused_strb = ^inport_tstrb_i;

    // A frame committing into the last free slot next cycle also blocks, so a
    // final beat accepted now can never find the FIFO full on its commit edge.
    assign inport_tready_o = ~(fifo_full | (commit_q & (level == LW'(FIFO_DEPTH - 1))));
    assign beat_fire       = inport_tvalid_i & inport_tready_o;
    assign dest_ok         = (inport_tdest_i == 4'(DEST_ID));
    assign last_beat       = (beat_q == BW'(BEATS - 1));

    always_comb begin
        beat_d      = beat_q;
        frame_d     = frame_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        if (beat_fire && dest_ok) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (c / 2 == int'(beat_q)) begin
                    frame_d[c*16 +: 16] = (c % 2 == 1) ? inport_tdata_i[31:16]
                                                       : inport_tdata_i[15:0];
                end
            end
            if (last_beat) begin
                beat_d      = '0;
                commit_d    = 1'b1;
                frame_err_d = ~inport_tlast_i;
            end else if (inport_tlast_i) begin
                // Early tlast: the partial frame is abandoned.
                beat_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    assign tick = audio_clk_i & ~audio_clk_q;
    assign pop  = tick & ~fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q      <= '0;
            frame_q     <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            audio_clk_q <= 1'b0;
            pop_data_q  <= '0;
            load_q      <= 1'b0;
            mute_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            frame_q     <= frame_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
            audio_clk_q <= audio_clk_i;
            if (pop) begin
                pop_data_q <= head;
            end
            load_q     <= pop;
            mute_q     <= tick & fifo_empty & (UNDER_MUTE != 0);
            underrun_q <= tick & fifo_empty;
        end
    end

    // Channel registers hold offset-binary codes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_q <= {NCH{MIDSCALE}};
        end else if (load_q) begin
            for (int c = 0; c < int'(NCH); c++) begin
                ch_q[c] <= {~pop_data_q[c*16+15], pop_data_q[c*16 +: 15]};
            end
        end else if (mute_q) begin
            ch_q <= {NCH{MIDSCALE}};
        end
    end

    audio_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (commit_q),
        .wdata_i (frame_q),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    for (genvar c = 0; c < int'(NCH); c++) begin : g_ch
        sigma_dac #(
            .NBITS (NBITS)
        ) u_dac (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .din_i  (ch_q[c][15 -: NBITS]),
            .dout_o (audio_o[c])
        );
    end

    assign level_o     = level;
    assign underrun_o  = underrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_audio_dac_mc.sv
// Self-checking bench: DUT a (NCH=3, hold on underrun) runs the bulk of the tests against a
// queue-based frame model; DUT b (NCH=2, mute on underrun) covers full-scale output and muting.
module tb_audio_dac_mc;

    localparam int A_NCH   = 3;
    localparam int A_BEATS = (A_NCH + 1) / 2;
    localparam int DEPTH   = 8;

    typedef logic [A_NCH*16-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a signals
    logic        a_aclk = 1'b0, a_tvalid = 1'b0, a_tlast = 1'b0, a_tready;
    logic [31:0] a_tdata = '0;
    logic [3:0]  a_tdest = '0;
    logic [2:0]  a_audio;
    logic [3:0]  a_level;
    logic        a_underrun, a_frame_err;

    // DUT b signals
    logic        b_aclk = 1'b0, b_tvalid = 1'b0, b_tlast = 1'b0, b_tready;
    logic [31:0] b_tdata = '0;
    logic [1:0]  b_audio;
    logic [3:0]  b_level;
    logic        b_underrun, b_frame_err;

    audio_dac_mc #(.NCH(3), .NBITS(16), .FIFO_DEPTH(DEPTH), .DEST_ID(0), .UNDER_MUTE(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .audio_clk_i(a_aclk), .inport_tvalid_i(a_tvalid),
        .inport_tdata_i(a_tdata), .inport_tstrb_i(4'hf), .inport_tdest_i(a_tdest),
        .inport_tlast_i(a_tlast), .inport_tready_o(a_tready), .audio_o(a_audio),
        .level_o(a_level), .underrun_o(a_underrun), .frame_err_o(a_frame_err)
    );

    audio_dac_mc #(.NCH(2), .NBITS(16), .FIFO_DEPTH(DEPTH), .DEST_ID(0), .UNDER_MUTE(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .audio_clk_i(b_aclk), .inport_tvalid_i(b_tvalid),
        .inport_tdata_i(b_tdata), .inport_tstrb_i(4'hf), .inport_tdest_i(4'h0),
        .inport_tlast_i(b_tlast), .inport_tready_o(b_tready), .audio_o(b_audio),
        .level_o(b_level), .underrun_o(b_underrun), .frame_err_o(b_frame_err)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model for DUT a
    frame_t      a_fq[$];
    logic [15:0] a_part[$];
    logic [15:0] a_reg_exp[A_NCH];
    int          a_err_exp = 0, a_ur_exp = 0;

    // Pulse-cycle counters (each event must be exactly one cycle high)
    int a_err_seen = 0, a_ur_seen = 0, b_ur_seen = 0;
    always @(negedge clk) begin
        if (a_underrun)  a_ur_seen++;
        if (a_frame_err) a_err_seen++;
        if (b_underrun)  b_ur_seen++;
    end

    function automatic void a_model_reset();
        a_fq.delete();
        a_part.delete();
        for (int c = 0; c < A_NCH; c++) a_reg_exp[c] = 16'h8000;
    endfunction

    // Samples accumulate until a frame's worth of beats has arrived.
    function automatic void a_model_beat(input logic [31:0] d, input logic [3:0] dest,
                                         input logic last);
        frame_t f;
        if (dest != 4'd0) return;
        a_part.push_back(d[15:0]);
        a_part.push_back(d[31:16]);
        if (a_part.size() == 2 * A_BEATS) begin
            f = '0;
            for (int c = 0; c < A_NCH; c++) f[c*16 +: 16] = a_part[c];
            a_fq.push_back(f);
            if (!last) a_err_exp++;
            a_part.delete();
        end else if (last) begin
            a_part.delete();
            a_err_exp++;
        end
    endfunction

    function automatic void a_model_tick();
        frame_t f;
        if (a_fq.size() > 0) begin
            f = a_fq.pop_front();
            for (int c = 0; c < A_NCH; c++) a_reg_exp[c] = f[c*16 +: 16] ^ 16'h8000;
        end else begin
            a_ur_exp++;
        end
    endfunction

    task automatic a_send(input logic [31:0] d, input logic [3:0] dest, input logic last);
        int n;
        n = 0;
        @(posedge clk); #1;
        a_tdata = d; a_tdest = dest; a_tlast = last; a_tvalid = 1'b1;
        @(negedge clk);
        while (!a_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_tready) begin
            nvec++; nerr++;
            $display("FAIL a_send_timeout tready=%b required 1", a_tready);
        end else begin
            @(posedge clk);
            a_model_beat(d, dest, last);
        end
        #1 a_tvalid = 1'b0; a_tlast = 1'b0;
    endtask

    task automatic b_send(input logic [31:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        b_tdata = d; b_tlast = 1'b1; b_tvalid = 1'b1;
        @(negedge clk);
        while (!b_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b_tready) begin
            nvec++; nerr++;
            $display("FAIL b_send_timeout tready=%b required 1", b_tready);
        end else begin
            @(posedge clk);
        end
        #1 b_tvalid = 1'b0; b_tlast = 1'b0;
    endtask

    task automatic a_tick(input int hold);
        @(posedge clk); #1;
        a_aclk = 1'b1;
        a_model_tick();
        repeat (hold) @(posedge clk);
        #1 a_aclk = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (a_level !== 4'd0) begin nerr++; $display("FAIL reset_level got=%0d exp=0", a_level); end
        nvec++; if (a_audio !== 3'b000 || b_audio !== 2'b00) begin
            nerr++; $display("FAIL reset_audio got=%b/%b exp=0", a_audio, b_audio); end
        nvec++; if (a_underrun !== 1'b0 || a_frame_err !== 1'b0) begin
            nerr++; $display("FAIL reset_pulses got=%b%b exp=00", a_underrun, a_frame_err); end
        for (int c = 0; c < A_NCH; c++) begin
            nvec++; if (dut_a.ch_q[c] !== 16'h8000) begin
                nerr++; $display("FAIL reset_ch%0d got=%h exp=8000", c, dut_a.ch_q[c]); end
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        nvec++; if (a_tready !== 1'b1 || b_tready !== 1'b1) begin
            nerr++; $display("FAIL reset_tready got=%b/%b exp=1", a_tready, b_tready); end
    endtask

    task automatic test_stereo_full_scale();
        int ones1, ones0;
        b_send(32'h7FFF_8000);
        settle();
        nvec++; if (b_level !== 4'd1) begin nerr++; $display("FAIL b_level got=%0d exp=1", b_level); end
        @(posedge clk); #1 b_aclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++; if (dut_b.ch_q[1] !== 16'h8000) begin
            nerr++; $display("FAIL b_load_early got=%h exp=8000", dut_b.ch_q[1]); end
        @(negedge clk);
        nvec++; if (dut_b.ch_q[1] !== 16'hFFFF || dut_b.ch_q[0] !== 16'h0000) begin
            nerr++; $display("FAIL b_load got=%h/%h exp=ffff/0000", dut_b.ch_q[1], dut_b.ch_q[0]); end
        b_aclk = 1'b0;
        ones1 = 0; ones0 = 0;
        repeat (1024) begin
            @(negedge clk);
            ones1 += int'(b_audio[1]);
            ones0 += int'(b_audio[0]);
        end
        nvec++; if (ones1 < 1016) begin nerr++; $display("FAIL b_density_r got=%0d exp>=1016", ones1); end
        nvec++; if (ones0 != 0) begin nerr++; $display("FAIL b_density_l got=%0d exp=0", ones0); end
    endtask

    task automatic test_three_channel();
        a_send(32'h0002_0001, 4'd0, 1'b0);
        a_send(32'h0000_0003, 4'd0, 1'b1);
        settle();
        nvec++; if (a_level !== 4'd1) begin nerr++; $display("FAIL a3_level got=%0d exp=1", a_level); end
        a_tick(1);
        settle();
        for (int c = 0; c < A_NCH; c++) begin
            nvec++; if (dut_a.ch_q[c] !== a_reg_exp[c]) begin
                nerr++; $display("FAIL a3_ch%0d got=%h exp=%h", c, dut_a.ch_q[c], a_reg_exp[c]); end
        end
        nvec++; if (dut_a.ch_q[2] !== 16'h8003) begin
            nerr++; $display("FAIL a3_ch2_const got=%h exp=8003", dut_a.ch_q[2]); end
    endtask

    task automatic test_framing();
        a_send(32'h1234_5678, 4'd0, 1'b1);      // tlast on beat 0
        settle();
        nvec++; if (a_level !== 4'(a_fq.size()) || a_err_seen != a_err_exp) begin
            nerr++; $display("FAIL early_tlast level=%0d err=%0d exp %0d/%0d",
                             a_level, a_err_seen, a_fq.size(), a_err_exp); end
        a_send(32'h0005_0004, 4'd0, 1'b0);
        a_send(32'h0000_0006, 4'd0, 1'b1);
        a_send(32'h0008_0007, 4'd0, 1'b0);
        a_send(32'hDEAD_BEEF, 4'd5, 1'b1);      // foreign tdest: dropped silently
        a_send(32'h0000_0009, 4'd0, 1'b1);
        a_send(32'h000B_000A, 4'd0, 1'b0);
        a_send(32'h0000_000C, 4'd0, 1'b0);      // final beat without tlast
        settle();
        nvec++; if (a_level !== 4'(a_fq.size()) || a_level !== 4'd3) begin
            nerr++; $display("FAIL framing_level got=%0d exp=3", a_level); end
        nvec++; if (a_err_seen != a_err_exp) begin
            nerr++; $display("FAIL framing_err got=%0d exp=%0d", a_err_seen, a_err_exp); end
        while (a_fq.size() > 0) begin
            a_tick(1);
            settle();
            for (int c = 0; c < A_NCH; c++) begin
                nvec++; if (dut_a.ch_q[c] !== a_reg_exp[c]) begin
                    nerr++; $display("FAIL framing_ch%0d got=%h exp=%h", c, dut_a.ch_q[c],
                                     a_reg_exp[c]); end
            end
        end
    endtask

    task automatic test_fill();
        for (int f = 0; f < DEPTH; f++) begin
            a_send($urandom, 4'd0, 1'b0);
            a_send($urandom, 4'd0, 1'b1);
        end
        settle();
        nvec++; if (a_level !== 4'd8 || a_tready !== 1'b0) begin
            nerr++; $display("FAIL fill level=%0d tready=%b exp 8/0", a_level, a_tready); end
        a_tick(1);
        settle();
        nvec++; if (a_level !== 4'd7) begin nerr++; $display("FAIL fill_pop got=%0d exp=7", a_level); end
        // Commit and pop on the same edge
        a_send($urandom, 4'd0, 1'b0);
        @(posedge clk); #1;
        a_tdata = $urandom; a_tdest = 4'd0; a_tlast = 1'b1; a_tvalid = 1'b1;
        @(negedge clk);
        nvec++;
        if (a_tready !== 1'b1) begin
            nerr++; $display("FAIL fill_ready got=%b exp=1", a_tready);
            #1 a_tvalid = 1'b0;
        end else begin
            @(posedge clk);
            a_model_beat(a_tdata, 4'd0, 1'b1);
            #1 a_tvalid = 1'b0; a_tlast = 1'b0; a_aclk = 1'b1;
            a_model_tick();
            @(posedge clk); #1 a_aclk = 1'b0;
            @(negedge clk);
            nvec++; if (a_level !== 4'd7) begin
                nerr++; $display("FAIL push_pop_level got=%0d exp=7", a_level); end
        end
        settle();
        nvec++; if (a_level !== 4'(a_fq.size())) begin
            nerr++; $display("FAIL fill_settle got=%0d exp=%0d", a_level, a_fq.size()); end
        for (int c = 0; c < A_NCH; c++) begin
            nvec++; if (dut_a.ch_q[c] !== a_reg_exp[c]) begin
                nerr++; $display("FAIL fill_ch%0d got=%h exp=%h", c, dut_a.ch_q[c], a_reg_exp[c]); end
        end
    endtask

    task automatic test_underrun();
        int b_before;
        while (a_fq.size() > 0) a_tick(1);
        settle();
        a_tick(2);                               // empty: underrun, registers hold
        settle();
        nvec++; if (a_ur_seen != a_ur_exp) begin
            nerr++; $display("FAIL a_underrun cycles=%0d exp=%0d", a_ur_seen, a_ur_exp); end
        for (int c = 0; c < A_NCH; c++) begin
            nvec++; if (dut_a.ch_q[c] !== a_reg_exp[c]) begin
                nerr++; $display("FAIL a_hold_ch%0d got=%h exp=%h", c, dut_a.ch_q[c], a_reg_exp[c]); end
        end
        b_before = b_ur_seen;
        @(posedge clk); #1 b_aclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 b_aclk = 1'b0;
        settle();
        nvec++; if (b_ur_seen != b_before + 1) begin
            nerr++; $display("FAIL b_underrun cycles=%0d exp=%0d", b_ur_seen - b_before, 1); end
        nvec++; if (dut_b.ch_q[1] !== 16'h8000 || dut_b.ch_q[0] !== 16'h8000) begin
            nerr++; $display("FAIL b_mute got=%h/%h exp=8000", dut_b.ch_q[1], dut_b.ch_q[0]); end
    endtask

    task automatic test_random();
        int op;
        logic [3:0] dest;
        logic last;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if (op < 7 && a_fq.size() < DEPTH) begin
                dest = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                last = (a_part.size() / 2 == A_BEATS - 1);
                if ($urandom_range(0, 9) == 0) last = ~last;
                a_send($urandom, dest, last);
            end else begin
                a_tick($urandom_range(1, 3));
            end
            settle();
            nvec++; if (a_level !== 4'(a_fq.size())) begin
                nerr++; $display("FAIL rnd%0d_level got=%0d exp=%0d", i, a_level, a_fq.size()); end
            for (int c = 0; c < A_NCH; c++) begin
                nvec++; if (dut_a.ch_q[c] !== a_reg_exp[c]) begin
                    nerr++; $display("FAIL rnd%0d_ch%0d got=%h exp=%h", i, c, dut_a.ch_q[c],
                                     a_reg_exp[c]); end
            end
            nvec++; if (a_err_seen != a_err_exp || a_ur_seen != a_ur_exp) begin
                nerr++; $display("FAIL rnd%0d_pulses err=%0d ur=%0d exp %0d/%0d", i, a_err_seen,
                                 a_ur_seen, a_err_exp, a_ur_exp); end
        end
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 3; f++) begin
            a_send($urandom, 4'd0, 1'b0);
            a_send($urandom, 4'd0, 1'b1);
        end
        a_send(32'h0000_0077, 4'd0, 1'b0);      // partial frame in flight
        settle();
        nvec++; if (a_level !== 4'(a_fq.size())) begin
            nerr++; $display("FAIL rm_pre_level got=%0d exp=%0d", a_level, a_fq.size()); end
        #3 rst_n = 1'b0;
        a_model_reset();
        repeat (2) @(negedge clk);
        nvec++; if (a_level !== 4'd0 || a_audio !== 3'b000) begin
            nerr++; $display("FAIL rm_level got=%0d audio=%b exp 0/0", a_level, a_audio); end
        for (int c = 0; c < A_NCH; c++) begin
            nvec++; if (dut_a.ch_q[c] !== 16'h8000) begin
                nerr++; $display("FAIL rm_ch%0d got=%h exp=8000", c, dut_a.ch_q[c]); end
        end
        @(posedge clk); #2 rst_n = 1'b1;
        a_send(32'h0000_0011, 4'd0, 1'b0);
        a_send(32'h0000_0022, 4'd0, 1'b1);
        a_send(32'h0000_0033, 4'd0, 1'b0);
        a_send(32'h0000_0044, 4'd0, 1'b1);
        settle();
        nvec++; if (a_level !== 4'd2 || a_err_seen != a_err_exp || a_ur_seen != a_ur_exp) begin
            nerr++; $display("FAIL rm_after level=%0d err=%0d ur=%0d exp 2/%0d/%0d", a_level,
                             a_err_seen, a_ur_seen, a_err_exp, a_ur_exp); end
        a_tick(50);                              // held high: one tick only
        settle();
        nvec++; if (a_level !== 4'd1 || a_ur_seen != a_ur_exp) begin
            nerr++; $display("FAIL rm_hold level=%0d ur=%0d exp 1/%0d", a_level, a_ur_seen,
                             a_ur_exp); end
        for (int c = 0; c < A_NCH; c++) begin
            nvec++; if (dut_a.ch_q[c] !== a_reg_exp[c]) begin
                nerr++; $display("FAIL rm_ch%0d_load got=%h exp=%h", c, dut_a.ch_q[c], a_reg_exp[c]); end
        end
    endtask

    initial begin
        test_reset();
        test_stereo_full_scale();
        test_three_channel();
        test_framing();
        test_fill();
        test_underrun();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
